// File: rtl/ram_n.sv
// ram_n: single-port word RAM with a built-in clear sweep.
//
// Reads are combinational. A clear request zeroes the array one word per
// clock. Reset starts the same sweep, so every word reads 0 once the first
// sweep completes.
//
// Ports
//   clk      in   1          single clock, rising edge
//   reset    in   1          asynchronous, active-high; forces CLEAR / ptr=0
//   in       in   WIDTH      write data
//   address  in   ADDR_BITS  read/write word address
//   load     in   1          write enable (honoured in IDLE only)
//   clear    in   1          start a clear sweep (honoured in IDLE only)
//   out      out  WIDTH      mem[address] when idle, 0 while busy
//   busy     out  1          registered, high while sweeping
//   done     out  1          registered one-cycle pulse at sweep completion
//   o_state  out  1          debug view of the FSM state (0=IDLE, 1=CLEAR)
//
// Control semantics: there is no valid/ready handshake. load and clear are
// level-sampled on each rising edge. In IDLE, clear beats load. While busy,
// both are ignored, and the sweep always runs to completion.
module ram_n #(
    parameter int WIDTH     = 16,
    parameter int ADDR_BITS = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     in,
    input  logic [ADDR_BITS-1:0] address,
    input  logic                 load,
    input  logic                 clear,
    output logic [WIDTH-1:0]     out,
    output logic                 busy,
    output logic                 done,
    output logic                 o_state
);

    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t               r_state;
    logic [ADDR_BITS-1:0] r_ptr;
    logic                 r_busy;
    logic                 r_done;
    logic [WIDTH-1:0]     r_mem [DEPTH];

    logic                 w_user_write;

    // A user write is only legal in IDLE, and a simultaneous clear wins.
    assign w_user_write = (r_state == IDLE) && load && !clear;

    // Control FSM. busy/done are registered alongside the state so that they
    // change on the same edge as the state itself.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= CLEAR;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (clear) begin
                        r_state <= CLEAR;
                        r_ptr   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    // ptr wraps naturally to 0 on the last word.
                    r_ptr <= r_ptr + 1'b1;
                    if (r_ptr == LAST_ADDR) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= CLEAR;
                    r_ptr   <= '0;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    // Storage has no reset: the sweep is what defines its contents. The sweep
    // write and the user write are exclusive because they depend on the state.
    always_ff @(posedge clk) begin
        if (r_state == CLEAR) begin
            r_mem[r_ptr] <= '0;
        end else if (w_user_write) begin
            r_mem[address] <= in;
        end
    end

    assign out     = r_busy ? '0 : r_mem[address];
    assign busy    = r_busy;
    assign done    = r_done;
    assign o_state = r_state;

endmodule

// File: tb/tb_ram_n.sv
`timescale 1ns/1ps
module tb_ram_n;

    localparam int W1 = 16;
    localparam int A1 = 3;
    localparam int D1 = 8;
    localparam int W2 = 8;
    localparam int A2 = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1;
    logic [W1-1:0] in = '0;
    logic [A1-1:0] address = '0;
    logic          load = 1'b0;
    logic          clear = 1'b0;
    logic [W1-1:0] out;
    logic          busy, done, st1;

    logic          reset2 = 1'b1;
    logic [W2-1:0] in2 = '0;
    logic [A2-1:0] address2 = '0;
    logic          load2 = 1'b0;
    logic          clear2 = 1'b0;
    logic [W2-1:0] out2;
    logic          busy2, done2, st2;

    ram_n dut (
        .clk(clk), .reset(reset), .in(in), .address(address), .load(load),
        .clear(clear), .out(out), .busy(busy), .done(done), .o_state(st1)
    );

    ram_n #(.WIDTH(W2), .ADDR_BITS(A2)) dut2 (
        .clk(clk), .reset(reset2), .in(in2), .address(address2), .load(load2),
        .clear(clear2), .out(out2), .busy(busy2), .done(done2), .o_state(st2)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (default DUT) ----------------
    // A sweep is "busy for D1 edges, zeroing words in ascending order".
    logic [W1-1:0] m_mem   [D1];
    bit            m_valid [D1];
    bit            m_busy  = 1'b1;
    bit            m_done  = 1'b0;
    int            m_left  = D1;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy = 1'b1;
            m_done = 1'b0;
            m_left = D1;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_mem[D1 - m_left]   = '0;
                m_valid[D1 - m_left] = 1'b1;
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end else if (clear) begin
                m_busy = 1'b1;
                m_left = D1;
            end else if (load) begin
                m_mem[address]   = in;
                m_valid[address] = 1'b1;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        if (m_busy)
            chk("out_busy", out, 0);
        else if (m_valid[address])
            chk("out_read", out, m_mem[address]);
    end

    // ---------------- driver helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step until busy falls; returns the number of edges taken.
    task automatic wait_idle(input string name, output int edges);
        edges = 0;
        while (busy) begin
            step();
            edges++;
            if (edges > 40) begin
                chk({name, "_timeout"}, 1, 0);
                break;
            end
        end
    endtask

    task automatic wait_idle2(output int edges);
        edges = 0;
        while (busy2) begin
            step();
            edges++;
            if (edges > 60) begin
                chk("dut2_timeout", 1, 0);
                break;
            end
        end
    endtask

    int e;
    int pulses;
    bit saw_ff;

    initial begin
        // Reset state
        #12;
        chk("rst_busy", busy, 1);
        chk("rst_done", done, 0);
        chk("rst_out", out, 0);
        step();
        reset = 1'b0;
        wait_idle("sweep0", e);
        chk("sweep0_edges", e, 8);
        chk("sweep0_done", done, 1);
        for (int i = 0; i < D1; i++) begin
            address = A1'(i);
            #0.4;
            chk("post_clear_read", out, 16'h0000);
        end
        step();
        chk("done_one_cycle", done, 0);

        // Writes with immediate readback, then combinational read sweep
        for (int i = 0; i < D1; i++) begin
            load = 1'b1;
            address = A1'(i);
            in = W1'(i + 1);
            step();
            chk("write_readback", out, W1'(i + 1));
        end
        load = 1'b0;
        in = '0;
        for (int i = 0; i < D1; i++) begin
            address = A1'(i);
            #0.4;
            chk("comb_read", out, W1'(i + 1));
        end
        step();

        // Loads and a second clear during a sweep are ignored
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clear_busy", busy, 1);
        load = 1'b1;
        address = 3'd5;
        in = 16'hBEEF;
        for (int i = 0; i < 4; i++) begin
            clear = (i == 1);
            step();
        end
        clear = 1'b0;
        load = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done) pulses++;
        end
        chk("done_pulses", pulses, 1);
        chk("addr5_cleared", out, 16'h0000);

        // Clear beats a simultaneous load
        load = 1'b1;
        address = 3'd3;
        in = 16'h0004;
        step();
        chk("addr3_written", out, 16'h0004);
        clear = 1'b1;
        in = 16'h00FF;
        step();
        clear = 1'b0;
        load = 1'b0;
        chk("prio_busy", busy, 1);
        saw_ff = 1'b0;
        e = 0;
        while (busy && e < 40) begin
            if (out == 16'h00FF) saw_ff = 1'b1;
            step();
            e++;
        end
        chk("prio_edges", e, 8);
        chk("prio_no_ff", saw_ff, 0);
        chk("prio_addr3_zero", out, 16'h0000);
        chk("prio_done", done, 1);

        // Clear accepted on the cycle done is high
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("b2b_busy", busy, 1);
        chk("b2b_done", done, 0);
        wait_idle("b2b", e);
        chk("b2b_edges", e, 8);

        // Reset mid-sweep restarts from ptr 0
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < 4; i++) step();
        reset = 1'b1;
        #1;
        chk("midrst_busy", busy, 1);
        chk("midrst_done", done, 0);
        chk("midrst_out", out, 0);
        step();
        reset = 1'b0;
        pulses = 0;
        e = 0;
        while (busy && e < 40) begin
            step();
            e++;
            if (done && busy) pulses++;
        end
        chk("midrst_edges", e, 8);
        chk("midrst_no_early_done", pulses, 0);
        chk("midrst_done_end", done, 1);

        // Second configuration: 8-bit x 16 words
        reset2 = 1'b0;
        wait_idle2(e);
        chk("dut2_sweep_edges", e, 16);
        chk("dut2_done", done2, 1);
        load2 = 1'b1;
        address2 = 4'd15;
        in2 = 8'hAB;
        step();
        address2 = 4'd0;
        in2 = 8'hCD;
        step();
        load2 = 1'b0;
        address2 = 4'd15;
        #0.4;
        chk("dut2_addr15", out2, 8'hAB);
        address2 = 4'd0;
        #0.4;
        chk("dut2_addr0", out2, 8'hCD);
        address2 = 4'd1;
        #0.4;
        chk("dut2_addr1", out2, 8'h00);
        address2 = 4'd14;
        #0.4;
        chk("dut2_addr14", out2, 8'h00);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_n.md
RAM_N -- requirements
Module: ram_n

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width in bits (>=1).
REQ-002 SHALL have parameter ADDR_BITS, default 3, address width; DEPTH = 2**ADDR_BITS words.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in  input  WIDTH  write data.
REQ-006 SHALL have port address  input  ADDR_BITS  read/write word address.
REQ-007 SHALL have port load  input  1  write enable, sampled on rising clk.
REQ-008 SHALL have port clear  input  1  request to zero the whole array, sampled on rising clk.
REQ-009 SHALL have port out  output  WIDTH  read data.
REQ-010 SHALL have port busy  output  1  high while a clear sweep is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse when a clear sweep completes.

Function
REQ-012 SHALL implement a two-state FSM: IDLE and CLEAR, with a registered sweep pointer ptr of ADDR_BITS bits.
REQ-013 SHALL drive out = mem[address] combinationally (no clock latency) when busy=0, and out = 0 when busy=1.
REQ-014 SHALL, in IDLE with load=1 and clear=0 at a rising edge, write in to mem[address]; out reflects the new value after that edge with no further delay.
REQ-015 SHALL leave memory unchanged on an edge with load=0, regardless of in and address.
REQ-016 SHALL, in IDLE with clear=1 at a rising edge, enter CLEAR with ptr=0; a simultaneous load SHALL be ignored (clear has priority).
REQ-017 SHALL, in CLEAR, write 0 to mem[ptr] on every rising edge and increment ptr; the edge that writes word DEPTH-1 returns the FSM to IDLE and wraps ptr to 0.
REQ-018 SHALL complete a sweep in exactly DEPTH rising edges.
REQ-019 SHALL ignore load in CLEAR (no user write reaches memory while busy=1).
REQ-020 SHALL ignore clear in CLEAR (no restart; the sweep continues to completion).
REQ-021 SHALL drive busy registered, equal to (state == CLEAR).
REQ-022 SHALL drive done registered: high for exactly one cycle after the edge that writes word DEPTH-1 (coincident with busy falling), low otherwise.
REQ-023 SHALL accept clear=1 on the same edge that done rises, starting a new sweep on that edge's successor: done=1, busy=0 in that cycle, then busy=1.

Reset
REQ-024 SHALL, on reset=1, immediately (asynchronously) set state=CLEAR, ptr=0, busy=1, done=0, and hence out=0.
REQ-025 SHALL hold state at CLEAR/ptr=0 while reset=1; the sweep begins on the first rising edge after reset deasserts and completes DEPTH edges later.
REQ-026 SHALL, on reset asserted mid-sweep, restart the sweep at ptr=0; memory contents need not be preserved.
REQ-027 SHALL not require memory contents to be defined before the first sweep completes; every word reads 0 after it completes.

Verification
REQ-028 Default params: pulse reset, release -> busy=1, out=0; after 8 edges busy=0, done=1 for one cycle; addresses 0..7 all read 0x0000.
REQ-029 After clear: load=1, write 0x0001..0x0008 to addresses 0..7 -> each reads back right after its edge; then load=0, in=0, sweep address 0..7 -> reads 0x0001..0x0008 with no clock edges.
REQ-030 During a sweep, load=1, address=5, in=0xBEEF -> after sweep address 5 reads 0x0000; done pulses exactly once.
REQ-031 IDLE, address 3 holds 0x0004: clear=1 and load=1 with in=0x00FF on same edge -> busy=1 next cycle, address 3 never shows 0x00FF, reads 0x0000 after 8 edges.
REQ-032 Reset asserted after 4 sweep edges, released -> busy stays 1, done stays 0, sweep finishes exactly 8 edges after release.
REQ-033 WIDTH=8, ADDR_BITS=4: sweep takes 16 edges; write 0xAB to address 15 and 0xCD to address 0 -> read 0xAB and 0xCD; no aliasing at the pointer wrap.
